// File: rtl/my_stim_chk.sv
// Stimulus generator and checker for the "my" increment datapath.
// Drives a deterministic vector sequence and checks each response against in+1 after LATENCY cycles.
module my_stim_chk #(
   parameter int unsigned LATENCY = 0,
   parameter logic [39:0] SEED_Q  = 40'hFF_FFFF_FFF8,
   parameter logic [69:0] SEED_W  = 70'h0_FFFF_FFFF_FFFF_FFF0
) (
   input  logic        clk,
   input  logic        reset_l,
   input  logic        start,
   input  logic [31:0] num_vectors,
   output logic [1:0]  in_small,
   output logic [39:0] in_quad,
   output logic [69:0] in_wide,
   input  logic [1:0]  out_small,
   input  logic [39:0] out_quad,
   input  logic [69:0] out_wide,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [15:0] err_count,
   output logic [31:0] first_err_idx
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   typedef struct packed {
      logic        vld;
      logic [31:0] idx;
      logic [1:0]  exp_small;
      logic [39:0] exp_quad;
      logic [69:0] exp_wide;
   } chk_t;

   state_t      state_q, state_d;
   logic [31:0] k_q, k_d;
   logic [31:0] n_q, n_d;
   logic [1:0]  in_small_q, in_small_d;
   logic [39:0] in_quad_q, in_quad_d;
   logic [69:0] in_wide_q, in_wide_d;
   logic [15:0] err_q, err_d;
   logic [31:0] first_q, first_d;
   logic        pass_q, pass_d;

   chk_t        enq;
   chk_t        tap;
   logic        pipe_busy;
   logic        mismatch;

   // Entry formed from the vector being driven this cycle; the expected response is in+1 per port.
   always_comb begin
      enq           = '0;
      enq.vld       = (state_q == S_RUN);
      enq.idx       = k_q;
      enq.exp_small = in_small_q + 2'd1;
      enq.exp_quad  = in_quad_q + 40'd1;
      enq.exp_wide  = in_wide_q + 70'd1;
   end

   generate
      if (LATENCY == 0) begin : g_nolat
         assign tap       = enq;
         assign pipe_busy = 1'b0;
      end else begin : g_lat
         chk_t pipe_q [LATENCY];

         always_ff @(posedge clk or negedge reset_l) begin
            if (!reset_l) begin
               for (int unsigned i = 0; i < LATENCY; i++) begin
                  pipe_q[i] <= '0;
               end
            end else begin
               pipe_q[0] <= enq;
               for (int unsigned i = 1; i < LATENCY; i++) begin
                  pipe_q[i] <= pipe_q[i-1];
               end
            end
         end

         always_comb begin
            pipe_busy = 1'b0;
            for (int unsigned i = 0; i < LATENCY; i++) begin
               pipe_busy = pipe_busy | pipe_q[i].vld;
            end
         end

         assign tap = pipe_q[LATENCY-1];
      end
   endgenerate

   assign mismatch = tap.vld &&
                     ((out_small != tap.exp_small) ||
                      (out_quad  != tap.exp_quad)  ||
                      (out_wide  != tap.exp_wide));

   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         state_q    <= S_IDLE;
         k_q        <= '0;
         n_q        <= '0;
         in_small_q <= '0;
         in_quad_q  <= '0;
         in_wide_q  <= '0;
         err_q      <= '0;
         first_q    <= '1;
         pass_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         k_q        <= k_d;
         n_q        <= n_d;
         in_small_q <= in_small_d;
         in_quad_q  <= in_quad_d;
         in_wide_q  <= in_wide_d;
         err_q      <= err_d;
         first_q    <= first_d;
         pass_q     <= pass_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      k_d        = k_q;
      n_d        = n_q;
      in_small_d = in_small_q;
      in_quad_d  = in_quad_q;
      in_wide_d  = in_wide_q;
      err_d      = err_q;
      first_d    = first_q;
      pass_d     = pass_q;

      if (mismatch) begin
         if (err_q != '1) begin
            err_d = err_q + 16'd1;
         end
         if (first_q == '1) begin
            first_d = tap.idx;
         end
      end

      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               err_d   = '0;
               first_d = '1;
               pass_d  = 1'b0;
               n_d     = num_vectors;
               k_d     = '0;
               if (num_vectors == '0) begin
                  state_d = S_DONE;
                  pass_d  = 1'b1;
               end else begin
                  state_d    = S_RUN;
                  in_small_d = '0;
                  in_quad_d  = SEED_Q;
                  in_wide_d  = SEED_W;
               end
            end
         end
         S_RUN: begin
            // Successive vectors differ by exactly one, so each port simply increments.
            if (k_q == n_q - 32'd1) begin
               state_d    = S_DRAIN;
               in_small_d = '0;
               in_quad_d  = '0;
               in_wide_d  = '0;
            end else begin
               k_d        = k_q + 32'd1;
               in_small_d = in_small_q + 2'd1;
               in_quad_d  = in_quad_q + 40'd1;
               in_wide_d  = in_wide_q + 70'd1;
            end
         end
         S_DRAIN: begin
            if (!pipe_busy) begin
               state_d = S_DONE;
               pass_d  = (err_q == '0);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign in_small      = in_small_q;
   assign in_quad       = in_quad_q;
   assign in_wide       = in_wide_q;
   assign busy          = (state_q == S_RUN) || (state_q == S_DRAIN);
   assign done          = (state_q == S_DONE);
   assign pass          = pass_q;
   assign err_count     = err_q;
   assign first_err_idx = first_q;

endmodule

// File: tb/tb_my_stim_chk.sv
// Bench for my_stim_chk: three checker instances (latency 0, 3 and 2) facing behavioural DUTs,
// compared every cycle against a closed-form timeline model of each run.
module tb_my_stim_chk;

   localparam logic [39:0] SQ = 40'hFF_FFFF_FFF8;
   localparam logic [69:0] SW = 70'h0_FFFF_FFFF_FFFF_FFF0;
   localparam int LAT [3] = '{0, 3, 2};
   localparam int DLY [3] = '{0, 3, 3};

   logic clk = 1'b0;
   logic reset_l = 1'b0;
   logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
   logic [31:0] num_a = '0, num_bc = '0;
   logic stuck_a = 1'b0;

   logic [1:0]  in_small_a, in_small_b, in_small_c, out_small_a, out_small_b, out_small_c;
   logic [39:0] in_quad_a, in_quad_b, in_quad_c, out_quad_a, out_quad_b, out_quad_c;
   logic [69:0] in_wide_a, in_wide_b, in_wide_c, out_wide_a, out_wide_b, out_wide_c;
   logic        busy_a, busy_b, busy_c, done_a, done_b, done_c, pass_a, pass_b, pass_c;
   logic [15:0] err_a, err_b, err_c;
   logic [31:0] first_a, first_b, first_c;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   bit chk_en = 1'b0;
   int base;

   bit have_run [3];
   int t0 [3];
   int nvec [3];
   bit mm [3][64];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   my_stim_chk #(.LATENCY(0)) u_a (
      .clk(clk), .reset_l(reset_l), .start(start_a), .num_vectors(num_a),
      .in_small(in_small_a), .in_quad(in_quad_a), .in_wide(in_wide_a),
      .out_small(out_small_a), .out_quad(out_quad_a), .out_wide(out_wide_a),
      .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a), .first_err_idx(first_a));

   my_stim_chk #(.LATENCY(3)) u_b (
      .clk(clk), .reset_l(reset_l), .start(start_b), .num_vectors(num_bc),
      .in_small(in_small_b), .in_quad(in_quad_b), .in_wide(in_wide_b),
      .out_small(out_small_b), .out_quad(out_quad_b), .out_wide(out_wide_b),
      .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b), .first_err_idx(first_b));

   my_stim_chk #(.LATENCY(2)) u_c (
      .clk(clk), .reset_l(reset_l), .start(start_c), .num_vectors(num_bc),
      .in_small(in_small_c), .in_quad(in_quad_c), .in_wide(in_wide_c),
      .out_small(out_small_c), .out_quad(out_quad_c), .out_wide(out_wide_c),
      .busy(busy_c), .done(done_c), .pass(pass_c), .err_count(err_c), .first_err_idx(first_c));

   // Behavioural increment DUTs: combinational (with optional stuck-at-0 small port) and 3-stage pipes.
   always_comb begin
      out_small_a = stuck_a ? 2'b00 : in_small_a + 2'd1;
      out_quad_a  = in_quad_a + 40'd1;
      out_wide_a  = in_wide_a + 70'd1;
   end

   logic [1:0]  ps_b [3], ps_c [3];
   logic [39:0] pq_b [3], pq_c [3];
   logic [69:0] pw_b [3], pw_c [3];
   always @(posedge clk) begin
      ps_b[0] <= in_small_b + 2'd1; pq_b[0] <= in_quad_b + 40'd1; pw_b[0] <= in_wide_b + 70'd1;
      ps_c[0] <= in_small_c + 2'd1; pq_c[0] <= in_quad_c + 40'd1; pw_c[0] <= in_wide_c + 70'd1;
      for (int i = 1; i < 3; i++) begin
         ps_b[i] <= ps_b[i-1]; pq_b[i] <= pq_b[i-1]; pw_b[i] <= pw_b[i-1];
         ps_c[i] <= ps_c[i-1]; pq_c[i] <= pq_c[i-1]; pw_c[i] <= pw_c[i-1];
      end
   end
   assign out_small_b = ps_b[2]; assign out_quad_b = pq_b[2]; assign out_wide_b = pw_b[2];
   assign out_small_c = ps_c[2]; assign out_quad_c = pq_c[2]; assign out_wide_c = pw_c[2];

   function automatic logic [1:0] vec_s(input int k);
      logic [31:0] kk;
      kk = 32'(k);
      return kk[1:0];
   endfunction
   function automatic logic [39:0] vec_q(input int k);
      return SQ + 40'(k);
   endfunction
   function automatic logic [69:0] vec_w(input int k);
      return SW + 70'(k);
   endfunction

   function automatic bit model_busy(input int i, input int c);
      if (!have_run[i] || nvec[i] == 0) return 1'b0;
      return (c >= t0[i]) && (c < t0[i] + nvec[i] + LAT[i] + 1);
   endfunction

   // A run accepted at edge t drives vector k in cycle t+k; the response seen at its check
   // cycle t+k+LAT comes from whatever was driven DLY cycles earlier.
   task automatic arm(input int i, input int n, input int t, input bit stuck);
      int src;
      logic [1:0] is, os;
      logic [39:0] iq, oq;
      logic [69:0] iw, ow;
      have_run[i] = 1'b1;
      t0[i] = t;
      nvec[i] = n;
      for (int k = 0; k < 64; k++) mm[i][k] = 1'b0;
      for (int k = 0; k < n; k++) begin
         src = t + k + LAT[i] - DLY[i];
         if (src >= t && src < t + n) begin
            is = vec_s(src - t); iq = vec_q(src - t); iw = vec_w(src - t);
         end else begin
            is = '0; iq = '0; iw = '0;
         end
         os = stuck ? 2'b00 : is + 2'd1;
         oq = iq + 40'd1;
         ow = iw + 70'd1;
         mm[i][k] = (os != vec_s(k) + 2'd1) || (oq != vec_q(k) + 40'd1) || (ow != vec_w(k) + 70'd1);
      end
   endtask

   task automatic chk(input string nm, input logic [69:0] act, input logic [69:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
      end
   endtask

   task automatic cmp_inst(input int i, input string p, input logic [1:0] s, input logic [39:0] q,
                           input logic [69:0] w, input logic b, input logic d, input logic ps,
                           input logic [15:0] e, input logic [31:0] f);
      logic [1:0] es; logic [39:0] eq; logic [69:0] ew;
      logic eb, ed, ep; logic [15:0] ee; logic [31:0] ef;
      int c, fin;
      c = cyc;
      es = '0; eq = '0; ew = '0; eb = 1'b0; ed = 1'b0; ep = 1'b0; ee = '0; ef = '1;
      if (have_run[i]) begin
         if (nvec[i] == 0) begin
            ed = 1'b1; ep = 1'b1;
         end else begin
            fin = t0[i] + nvec[i] + LAT[i] + 1;
            if (c >= t0[i] && c < t0[i] + nvec[i]) begin
               es = vec_s(c - t0[i]); eq = vec_q(c - t0[i]); ew = vec_w(c - t0[i]);
            end
            eb = (c >= t0[i]) && (c < fin);
            ed = (c >= fin);
            for (int k = 0; k < nvec[i]; k++) begin
               if (mm[i][k] && (t0[i] + k + LAT[i] + 1 <= c)) begin
                  ee++;
                  if (ef == '1) ef = 32'(k);
               end
            end
            ep = ed && (ee == 0);
         end
      end
      chk({p, ".in_small"}, 70'(s), 70'(es));
      chk({p, ".in_quad"}, 70'(q), 70'(eq));
      chk({p, ".in_wide"}, w, ew);
      chk({p, ".busy"}, 70'(b), 70'(eb));
      chk({p, ".done"}, 70'(d), 70'(ed));
      chk({p, ".pass"}, 70'(ps), 70'(ep));
      chk({p, ".err_count"}, 70'(e), 70'(ee));
      chk({p, ".first_err_idx"}, 70'(f), 70'(ef));
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         cmp_inst(0, "A", in_small_a, in_quad_a, in_wide_a, busy_a, done_a, pass_a, err_a, first_a);
         cmp_inst(1, "B", in_small_b, in_quad_b, in_wide_b, busy_b, done_b, pass_b, err_b, first_b);
         cmp_inst(2, "C", in_small_c, in_quad_c, in_wide_c, busy_c, done_c, pass_c, err_c, first_c);
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   // Called at negedge+1; start is high for one cycle and the run (if accepted) begins at the next edge.
   task automatic go(input logic [2:0] mask, input int n);
      for (int i = 0; i < 3; i++) begin
         if (mask[i] && reset_l && !model_busy(i, cyc)) arm(i, n, cyc + 1, (i == 0) && stuck_a);
      end
      start_a = mask[0]; start_b = mask[1]; start_c = mask[2];
      num_a = 32'(n); num_bc = 32'(n);
      wait_cyc(1);
      start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 3; i++) have_run[i] = 1'b0;
      @(posedge clk);
      chk_en = 1'b1;
      wait_cyc(1);
      reset_l = 1'b1;
      wait_cyc(2);

      // Long run: quad wraps at k=7.
      go(3'b001, 20);
      base = cyc;
      wait_cyc(7);
      chk("A.k7_in_quad", 70'(in_quad_a), 70'(40'hFF_FFFF_FFFF));
      chk("A.k7_out_quad", 70'(out_quad_a), 70'd0);
      wait_cyc(13);
      chk("A.n20_done_at20", 70'(done_a), 70'd0);
      wait_cyc(1);
      chk("A.n20_done_at21", 70'(done_a), 70'd1);
      chk("A.n20_pass", 70'(pass_a), 70'd1);
      chk("A.n20_first", 70'(first_a), 70'(32'hFFFF_FFFF));

      // Carry past bit 63 at k=15.
      go(3'b001, 16);
      wait_cyc(15);
      chk("A.k15_in_wide", in_wide_a, 70'h0_FFFF_FFFF_FFFF_FFFF);
      chk("A.k15_out_wide", out_wide_a, 70'h1_0000_0000_0000_0000);
      wait_cyc(2);
      chk("A.n16_pass", 70'(pass_a), 70'd1);

      // Stuck-at-0 small port.
      stuck_a = 1'b1;
      go(3'b001, 8);
      wait_cyc(9);
      chk("A.stuck_done", 70'(done_a), 70'd1);
      chk("A.stuck_err", 70'(err_a), 70'd6);
      chk("A.stuck_first", 70'(first_a), 70'd0);
      chk("A.stuck_pass", 70'(pass_a), 70'd0);
      stuck_a = 1'b0;
      wait_cyc(2);

      // Matched latency 3 versus mismatched latency 2, both against a 3-stage DUT.
      go(3'b110, 5);
      base = cyc;
      wait_cyc(8);
      chk("B.done_at8", 70'(done_b), 70'd0);
      wait_cyc(1);
      chk("B.done_at9", 70'(done_b), 70'd1);
      chk("B.pass", 70'(pass_b), 70'd1);
      chk("C.pass", 70'(pass_c), 70'd0);
      chk("C.err", 70'(err_c), 70'd5);
      chk("C.first", 70'(first_c), 70'd0);

      // Empty run, then starts during a run and on the last check edge.
      go(3'b001, 0);
      chk("A.n0_done", 70'(done_a), 70'd1);
      chk("A.n0_pass", 70'(pass_a), 70'd1);
      go(3'b001, 10);
      wait_cyc(2);
      go(3'b001, 3);
      wait_cyc(6);
      go(3'b001, 3);
      chk("A.last_edge_start_busy", 70'(busy_a), 70'd1);
      wait_cyc(1);
      chk("A.n10_done", 70'(done_a), 70'd1);
      chk("A.n10_err", 70'(err_a), 70'd0);

      // Reset mid-run, then a clean run.
      go(3'b001, 10);
      wait_cyc(4);
      chk("A.k4_in_quad", 70'(in_quad_a), 70'(40'hFF_FFFF_FFFC));
      reset_l = 1'b0;
      for (int i = 0; i < 3; i++) have_run[i] = 1'b0;
      #1;
      chk("A.rst_busy", 70'(busy_a), 70'd0);
      chk("A.rst_in_quad", 70'(in_quad_a), 70'd0);
      chk("A.rst_in_wide", in_wide_a, 70'd0);
      chk("A.rst_first", 70'(first_a), 70'(32'hFFFF_FFFF));
      chk("A.rst_done", 70'(done_a), 70'd0);
      wait_cyc(2);
      reset_l = 1'b1;
      wait_cyc(2);
      go(3'b001, 6);
      wait_cyc(7);
      chk("A.post_rst_done", 70'(done_a), 70'd1);
      chk("A.post_rst_pass", 70'(pass_a), 70'd1);
      wait_cyc(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
